// File: rtl/golife_pkg.sv
// Shared types and constants for the golife sequencer slice.
// State encoding, stop-reason codes and the grid width helper.
package golife_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PACE  = 3'd2,
    ST_STEP  = 3'd3,
    ST_CHECK = 3'd4
  } state_e;

  localparam logic [2:0] REASON_NONE    = 3'd0;
  localparam logic [2:0] REASON_COUNT   = 3'd1;
  localparam logic [2:0] REASON_STABLE  = 3'd2;
  localparam logic [2:0] REASON_EXTINCT = 3'd3;
  localparam logic [2:0] REASON_USER    = 3'd4;

  function automatic int grid_w(input int side);
    return side * side;
  endfunction

endpackage

// File: rtl/golife_pace_timer.sv
// Loadable down-counter that paces free-run generations.
// Ports: clk, rst, load_i/val_i reload, en_i counts, done_o on last cycle.
module golife_pace_timer #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [DIVW-1:0] val_i,
  output logic            done_o
);

  logic [DIVW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // A value of 1 means this is the last pacing cycle; 0 is treated
  // the same so a stray empty count can never stall the run.
  assign done_o = en_i && (cnt_q <= DIVW'(1));

endmodule

// File: rtl/golife_seq_ctrl.sv
// Load/run sequencer for the golife array: seeds, steps, free-runs.
// Ports: cmd_* pulses, num_gens/period run setup, grid observe; load/run drive golife.
module golife_seq_ctrl
  import golife_pkg::*;
#(
  parameter int SIDEWIDTH = 10,
  parameter int GENW      = 16,
  parameter int DIVW      = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_load,
  input  logic                            cmd_start,
  input  logic                            cmd_step,
  input  logic                            cmd_stop,
  input  logic [GENW-1:0]                 num_gens,
  input  logic [DIVW-1:0]                 period,
  input  logic [grid_w(SIDEWIDTH)-1:0]    grid,
  output logic                            load,
  output logic                            run,
  output logic                            busy,
  output logic                            done,
  output logic [GENW-1:0]                 gen_count,
  output logic [2:0]                      stop_reason
);

  localparam int GW = grid_w(SIDEWIDTH);

  state_e          state_q, state_d;
  logic [GENW-1:0] gen_q, gen_d;
  logic [2:0]      reason_q, reason_d;
  logic            done_q, done_d;
  logic [GW-1:0]   snap_q, snap_d;
  logic [GENW-1:0] tgt_q, tgt_d;
  logic [DIVW-1:0] per_q, per_d;
  logic            step_q, step_d;
  logic            pend_q, pend_d;
  logic            load_q, run_q, busy_q;

  logic            tmr_load;
  logic [DIVW-1:0] tmr_val;
  logic            tmr_done;
  logic [GENW-1:0] new_cnt;
  logic [DIVW-1:0] per_in;
  logic            g_zero;
  logic            g_same;
  logic            cnt_hit;
  logic            stop_now;

  golife_pace_timer #(
    .DIVW (DIVW)
  ) u_pace (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .en_i   (state_q == ST_PACE),
    .val_i  (tmr_val),
    .done_o (tmr_done)
  );

  assign per_in  = (period == '0) ? DIVW'(1) : period;
  assign new_cnt = (gen_q == '1) ? gen_q : gen_q + 1'b1;
  assign g_zero  = (grid == '0);
  assign g_same  = (grid == snap_q);
  assign cnt_hit = (tgt_q != '0) && (new_cnt == tgt_q);
  // A stop arriving in CHECK joins the pending request immediately.
  assign stop_now = pend_q || cmd_stop;

  always_comb begin
    state_d  = state_q;
    gen_d    = gen_q;
    reason_d = reason_q;
    done_d   = done_q;
    snap_d   = snap_q;
    tgt_d    = tgt_q;
    per_d    = per_q;
    step_d   = step_q;
    pend_d   = pend_q;
    tmr_load = 1'b0;
    tmr_val  = per_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_load) begin
          state_d  = ST_LOAD;
          gen_d    = '0;
          done_d   = 1'b0;
          reason_d = REASON_NONE;
        end else if (cmd_start) begin
          state_d  = ST_PACE;
          tgt_d    = num_gens;
          per_d    = per_in;
          done_d   = 1'b0;
          step_d   = 1'b0;
          pend_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = per_in;
        end else if (cmd_step) begin
          state_d = ST_STEP;
          done_d  = 1'b0;
          step_d  = 1'b1;
          pend_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      ST_PACE: begin
        if (cmd_stop) begin
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          reason_d = REASON_USER;
        end else if (tmr_done) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        // Capture the generation being replaced for the still-life test.
        snap_d  = grid;
        state_d = ST_CHECK;
        if (cmd_stop) begin
          pend_d = 1'b1;
        end
      end
      ST_CHECK: begin
        gen_d   = new_cnt;
        state_d = ST_IDLE;
        done_d  = 1'b1;
        pend_d  = 1'b0;
        unique case (1'b1)
          g_zero:   reason_d = REASON_EXTINCT;
          g_same:   reason_d = REASON_STABLE;
          cnt_hit:  reason_d = REASON_COUNT;
          stop_now: reason_d = REASON_USER;
          step_q:   reason_d = REASON_NONE;
          default: begin
            state_d  = ST_PACE;
            done_d   = 1'b0;
            tmr_load = 1'b1;
          end
        endcase
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gen_q    <= '0;
      reason_q <= REASON_NONE;
      done_q   <= 1'b0;
      snap_q   <= '0;
      tgt_q    <= '0;
      per_q    <= '0;
      step_q   <= 1'b0;
      pend_q   <= 1'b0;
      load_q   <= 1'b0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gen_q    <= gen_d;
      reason_q <= reason_d;
      done_q   <= done_d;
      snap_q   <= snap_d;
      tgt_q    <= tgt_d;
      per_q    <= per_d;
      step_q   <= step_d;
      pend_q   <= pend_d;
      // Output flops track the decode of the next state so they equal
      // the Moore decode of state_q without a combinational path.
      load_q   <= (state_d == ST_LOAD);
      run_q    <= (state_d == ST_STEP);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign load        = load_q;
  assign run         = run_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign gen_count   = gen_q;
  assign stop_reason = reason_q;

endmodule

// File: tb/tb_golife_seq_ctrl.sv
// Bench for golife_seq_ctrl with a behavioural golife array model.
// Expected run outcomes are queued at command time, popped on done.
module tb_golife_seq_ctrl;
  import golife_pkg::*;

  localparam int S    = 10;
  localparam int GENW = 16;
  localparam int DIVW = 8;
  localparam int GW   = S * S;

  logic            clk;
  logic            rst;
  logic            cmd_load, cmd_start, cmd_step, cmd_stop;
  logic [GENW-1:0] num_gens;
  logic [DIVW-1:0] period;
  logic [GW-1:0]   grid;
  logic            load, run, busy, done;
  logic [GENW-1:0] gen_count;
  logic [2:0]      stop_reason;

  logic [GW-1:0]   seed;
  logic [GW-1:0]   glider, blinker, block2, single;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_run = -1;
  int run_cnt = 0;
  int gap_bad = 0;
  int ovl = 0;
  int exp_gap = 0;
  int run_base = 0;

  typedef struct {
    string tag;
    int    gen;
    int    reason;
    int    runs;
  } exp_t;

  exp_t exp_q[$];

  golife_seq_ctrl #(
    .SIDEWIDTH (S),
    .GENW      (GENW),
    .DIVW      (DIVW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_load    (cmd_load),
    .cmd_start   (cmd_start),
    .cmd_step    (cmd_step),
    .cmd_stop    (cmd_stop),
    .num_gens    (num_gens),
    .period      (period),
    .grid        (grid),
    .load        (load),
    .run         (run),
    .busy        (busy),
    .done        (done),
    .gen_count   (gen_count),
    .stop_reason (stop_reason)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [GW-1:0] life_next(input logic [GW-1:0] g);
    logic [GW-1:0] n;
    int cnt, rr, cc;
    n = '0;
    for (int r = 0; r < S; r++) begin
      for (int c = 0; c < S; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < S &&
                cc >= 0 && cc < S && g[rr*S+cc])
              cnt++;
          end
        end
        if (g[r*S+c]) n[r*S+c] = (cnt == 2) || (cnt == 3);
        else          n[r*S+c] = (cnt == 3);
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst)       grid <= '0;
    else if (load) grid <= seed;
    else if (run)  grid <= life_next(grid);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load === 1'b1 && run === 1'b1) ovl <= ovl + 1;
    if (run === 1'b1) begin
      if (exp_gap != 0 && last_run >= 0 && cyc - last_run != exp_gap)
        gap_bad <= gap_bad + 1;
      last_run <= cyc;
      run_cnt  <= run_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [GW-1:0] s);
    seed     = s;
    cmd_load = 1'b1;
    tick();
    cmd_load = 1'b0;
    tick();
    tick();
  endtask

  task automatic push(input string tag, input int g, input int r,
                      input int n);
    exp_q.push_back('{tag, g, r, n});
    run_base = run_cnt;
  endtask

  task automatic do_start(input int ng, input int per);
    num_gens  = GENW'(ng);
    period    = DIVW'(per);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic do_step();
    cmd_step = 1'b1;
    tick();
    cmd_step = 1'b0;
  endtask

  task automatic expect_done(input int budget);
    exp_t e;
    int   k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    e = exp_q.pop_front();
    chk({e.tag, "_done"}, 32'(done), 1);
    chk({e.tag, "_busy"}, 32'(busy), 0);
    chk({e.tag, "_gen"}, 32'(gen_count), e.gen);
    chk({e.tag, "_reason"}, 32'(stop_reason), e.reason);
    chk({e.tag, "_runs"}, run_cnt - run_base, e.runs);
  endtask

  task automatic wait_runs(input int n, input int budget);
    int k;
    k = 0;
    while (run_cnt - run_base < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  initial begin
    int bad_rst;
    int k;

    glider  = '0;
    glider[12] = 1'b1; glider[23] = 1'b1;
    glider[31] = 1'b1; glider[32] = 1'b1; glider[33] = 1'b1;
    blinker = '0;
    blinker[43] = 1'b1; blinker[44] = 1'b1; blinker[45] = 1'b1;
    block2  = '0;
    block2[44] = 1'b1; block2[45] = 1'b1;
    block2[54] = 1'b1; block2[55] = 1'b1;
    single  = '0;
    single[55] = 1'b1;

    // Reset with random command traffic held on the inputs.
    rst     = 1'b1;
    bad_rst = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_load  = 1'($urandom);
      cmd_start = 1'($urandom);
      cmd_step  = 1'($urandom);
      cmd_stop  = 1'($urandom);
      num_gens  = GENW'($urandom);
      period    = DIVW'($urandom);
      seed      = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (load !== 1'b0 || run !== 1'b0) bad_rst++;
    end
    chk("rst_loadrun", bad_rst, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_gen", 32'(gen_count), 0);
    chk("rst_reason", 32'(stop_reason), 0);
    cmd_load = 0; cmd_start = 0; cmd_step = 0; cmd_stop = 0;
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Glider, four paced generations.
    do_load(glider);
    exp_gap = 3;
    push("t2", 4, REASON_COUNT, 4);
    do_start(4, 1);
    expect_done(100);
    chk("t2_gap", gap_bad, 0);
    exp_gap = 0;
    repeat (4) tick();
    chk("t2_hold", 32'(done), 1);

    // Still life and extinction, unlimited target.
    do_load(block2);
    push("t3blk", 1, REASON_STABLE, 1);
    do_start(0, 1);
    expect_done(50);
    do_load(single);
    push("t3one", 1, REASON_EXTINCT, 1);
    do_start(0, 0);
    expect_done(50);

    // User stop during pacing after the third generation.
    do_load(blinker);
    push("t4pace", 3, REASON_USER, 3);
    do_start(0, 5);
    wait_runs(3, 200);
    tick();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    expect_done(5);
    repeat (12) tick();
    chk("t4_norun", run_cnt - run_base, 3);

    // User stop landing on the fourth STEP cycle.
    do_load(blinker);
    push("t4step", 4, REASON_USER, 4);
    do_start(0, 5);
    k = 0;
    while (!(run === 1'b1 && run_cnt - run_base == 3) && k < 200) begin
      tick();
      k++;
    end
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    expect_done(10);

    // Single steps.
    do_load(blinker);
    push("t5s1", 1, REASON_NONE, 1);
    do_step();
    expect_done(10);
    push("t5s2", 2, REASON_NONE, 1);
    do_step();
    expect_done(10);

    // Simultaneous commands: load wins.
    run_base  = run_cnt;
    seed      = blinker;
    cmd_load  = 1'b1;
    cmd_start = 1'b1;
    cmd_step  = 1'b1;
    tick();
    cmd_load  = 1'b0;
    cmd_start = 1'b0;
    cmd_step  = 1'b0;
    chk("t5_load", 32'(load), 1);
    chk("t5_run", 32'(run), 0);
    tick();
    tick();
    chk("t5_gen", 32'(gen_count), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_busy", 32'(busy), 0);
    repeat (10) tick();
    chk("t5_noruns", run_cnt - run_base, 0);

    // Reset in the middle of pacing.
    do_load(blinker);
    run_base = run_cnt;
    do_start(0, 5);
    wait_runs(1, 100);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_gen", 32'(gen_count), 0);
    chk("t6_run", 32'(run), 0);
    repeat (15) tick();
    chk("t6_noruns", run_cnt - run_base, 1);
    chk("ovl", ovl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
